// File: rtl/shift_add_mac_seq.sv
// rtl/shift_add_mac_seq.sv - bit-serial shift-add unsigned multiply-accumulate sequencer
// Optional early exit on exhausted multiplier bits: SHIFT_ADD_MAC_EARLY_EXIT_EN
module shift_add_mac_seq #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ACC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             clr_q, clr_d;
    logic [PW-1:0]    partial_q, partial_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [PW-1:0]    addend;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;
    logic             last_bit;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid && (state_q == S_IDLE);
    assign out_fire = out_ready && (state_q == S_DONE);

    always_comb begin
        addend   = PW'(a_q) << count_q;
        acc_base = clr_q ? '0 : acc_q;
        // Extra top bit of the sum is the carry-out that feeds the sticky flag.
        acc_sum  = {1'b0, acc_base} + (ACC_W + 1)'(partial_q);
`ifdef SHIFT_ADD_MAC_EARLY_EXIT_EN
        last_bit = (b_q >> (count_q + CW'(1))) == '0;
`else
        last_bit = (count_q == CW'(WIDTH - 1));
`endif
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        a_d       = a_q;
        b_d       = b_q;
        clr_d     = clr_q;
        partial_d = partial_q;
        acc_d     = acc_q;
        result_d  = result_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    a_d       = op_a;
                    b_d       = op_b;
                    clr_d     = acc_clr;
                    partial_d = '0;
                    count_d   = '0;
`ifdef SHIFT_ADD_MAC_EARLY_EXIT_EN
                    state_d   = (op_b == '0) ? S_ACC : S_MUL;
`else
                    state_d   = S_MUL;
`endif
                end
            end
            S_MUL: begin
                if (b_q[count_q[$clog2(WIDTH)-1:0]]) begin
                    partial_d = partial_q + addend;
                end
                count_d = count_q + CW'(1);
                if (last_bit) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d    = acc_sum[ACC_W-1:0];
                result_d = acc_sum[ACC_W-1:0];
                ovf_d    = (clr_q ? 1'b0 : ovf_q) | acc_sum[ACC_W];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            clr_q     <= 1'b0;
            partial_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            a_q       <= a_d;
            b_q       <= b_d;
            clr_q     <= clr_d;
            partial_q <= partial_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_shift_add_mac_seq.sv
// tb/tb_shift_add_mac_seq.sv - scoreboard bench for shift_add_mac_seq
module tb_shift_add_mac_seq;

    localparam int WIDTH = 8;
    localparam int ACC_W = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             acc_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] result;
    logic             ovf;
    logic             busy;

    shift_add_mac_seq #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint res;
        logic   ovf;
        int     lat;
    } exp_t;

    exp_t   sb[$];
    longint acc_m = 0;
    logic   ovf_m = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] b);
        int hi;
`ifdef SHIFT_ADD_MAC_EARLY_EXIT_EN
        hi = -1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
        return 2 + hi + 1;
`else
        hi = b;
        return WIDTH + 2;
`endif
    endfunction

    task automatic push_model(input longint a, input longint b, input logic clr);
        exp_t   e;
        longint tot;
        tot   = (clr ? 0 : acc_m) + a * b;
        ovf_m = (clr ? 1'b0 : ovf_m) | (tot >= (longint'(1) << ACC_W));
        acc_m = tot % (longint'(1) << ACC_W);
        e.res = acc_m;
        e.ovf = ovf_m;
        e.lat = exp_lat(b[WIDTH-1:0]);
        sb.push_back(e);
    endtask

    // bp > 0 holds out_ready low for bp cycles in DONE while offering new input
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic clr, input int bp);
        int     lat;
        int     guard;
        exp_t   e;
        longint held;
        op_a      = a;
        op_b      = b;
        acc_clr   = clr;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        guard     = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check_eq("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        push_model(a, b, clr);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            check_eq("out_valid_timeout", out_valid, 1);
        end else begin
            check_eq("latency", lat, e.lat);
            check_eq("result", result, e.res);
            check_eq("ovf", ovf, e.ovf);
        end
        if (bp > 0) begin
            held     = result;
            op_a     = 8'd100;
            op_b     = 8'd100;
            acc_clr  = 1'b1;
            in_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                check_eq("bp_out_valid", out_valid, 1);
                check_eq("bp_result", result, held);
                check_eq("bp_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_eq("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        int stray;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'd13, 8'd11, 1'b1, 0);
        do_op(8'd255, 8'd255, 1'b0, 0);
        do_op(8'd0, 8'd77, 1'b1, 0);
        do_op(8'd200, 8'd1, 1'b1, 0);
        do_op(8'd5, 8'd0, 1'b0, 0);

        for (int i = 0; i < 17; i++) do_op(8'd255, 8'd255, (i == 0), 0);
        check_eq("wrap_result", result, 56849);
        check_eq("wrap_ovf", ovf, 1);
        do_op(8'd2, 8'd3, 1'b1, 0);
        check_eq("clr_result", result, 6);
        check_eq("clr_ovf", ovf, 0);

        do_op(8'd7, 8'd9, 1'b0, 5);
        do_op(8'd100, 8'd100, 1'b1, 0);

        op_a     = 8'd9;
        op_b     = 8'd9;
        acc_clr  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        acc_m = 0;
        ovf_m = 1'b0;
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_result", result, 0);
        check_eq("mid_rst_ovf", ovf, 0);
        stray = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        check_eq("no_stray_out_valid", stray, 0);

        do_op(8'd3, 8'd4, 1'b0, 0);
        check_eq("post_rst_accum", result, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
